control_miscare_param: RTL and testbench
========================================

Name: control_miscare_param

Overview:
- Clocked, parametrised successor of the combinational line-follower motion logic.
- Takes an N-sensor reflectance bar (1 = black), the circuit selection code and drive state, and produces per-driver direction codes and PWM compare factors.
- Contains a follow/search/stop state machine, a debounced lap counter with per-circuit stop rules, and a lost-line timeout.
- Sits between the sensor inputs and the PWM comparators / motor drivers.

Parameters:
- N_SENZ, 5, number of sensors; odd, >=5. Index 0 = right marker, N_SENZ-1 = left marker, C=(N_SENZ-1)/2 = centre.
- DC_W, 12, width of the PWM compare factors.
- DC_MAX, 12'h999, full-speed compare factor.
- DC_PAS, 12'h249, reduction per sensor of distance from centre.
- TURE_W, 8, lap counter width.
- DEBOUNCE, 4, cycles both markers must be stable before a finish edge is accepted.
- TIMEOUT_CAUTARE, 50000, maximum cycles in search before stopping.
- TURE_CIRCUIT2, 10, laps before stop on circuit 2'b10.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- senzori  in  N_SENZ  raw sensor bar, 1 = black, asynchronous to clk
- circuit  in  2  00 = idle/clear, 01 = straight (1 lap), 10 = curves (TURE_CIRCUIT2 laps), 11 = endurance (no limit)
- directie_driverA  out  2  10 = forward, 01 = reverse, 00 = brake
- directie_driverB  out  2  same encoding as directie_driverA
- factor_dc_driverA  out  DC_W  PWM compare factor for driver A
- factor_dc_driverB  out  DC_W  PWM compare factor for driver B
- semnal_dreapta  out  1  right turn indicator
- semnal_stanga  out  1  left turn indicator
- stop  out  1  brake light
- count_ture  out  TURE_W  laps completed
- pierdut  out  1  sticky: search timeout occurred
- stare  out  2  current FSM state, for debug

Behaviour:
- Reset values: directions 00; factors 0; count_ture 0; stop 1; pierdut 0; turn indicators 0; stare IDLE; side memory cleared.
- Input sync: senzori and circuit pass through a 2-FF synchroniser. All outputs are registered.
- Latency: a sensor change reaches the outputs 3 clk later.
- Side activity:
  - dr = any of senzori[1..C-1].
  - st = any of senzori[C+1..N_SENZ-2].
  - d_dr = distance from C of the farthest active right inner sensor (0 if none); d_st likewise for the left side.
- FSM states: IDLE=0, URMARIRE=1, CAUTARE=2, OPRIT=3.
- IDLE:
  - Directions 00, factors 0, stop=1.
  - Moves to URMARIRE when circuit != 00.
- URMARIRE:
  - Both directions 10, stop=0.
  - factor_dc_driverA = DC_MAX - d_dr*DC_PAS, saturating at 0; factor_dc_driverB = DC_MAX - d_st*DC_PAS, saturating at 0. If dr and st are both active, both factors = DC_MAX.
  - Side memory updates only when exactly one side is active: mem_dr=dr, mem_st=st.
  - Moves to CAUTARE when the centre sensor and all inner sensors are 0.
- CAUTARE:
  - Factors DC_MAX, stop=1.
  - mem_dr: A=01, B=10. mem_st: A=10, B=01. No memory: both 10.
  - Search counter increments each cycle.
  - Any inner or centre sensor = 1 moves to URMARIRE and clears the counter.
  - Counter reaching TIMEOUT_CAUTARE-1 moves to OPRIT and sets pierdut.
- OPRIT:
  - Directions 00, factors 0, stop=1.
  - Left only when circuit == 00.
- circuit == 00 from any state:
  - Next cycle: go to IDLE, clear count_ture, pierdut and side memory.
- Finish detection:
  - fin_raw = senzori[0] & senzori[N_SENZ-1] (synchronised).
  - fin_stabil changes only after fin_raw holds a new value for DEBOUNCE consecutive cycles.
  - A 0->1 edge of fin_stabil in URMARIRE or CAUTARE increments count_ture exactly once per finish line.
  - count_ture saturates at 2^TURE_W-1; no wrap.
- Stop rules, applied in the same cycle as the increment:
  - circuit 01 and new count >= 1: go to OPRIT.
  - circuit 10 and new count >= TURE_CIRCUIT2: go to OPRIT.
  - circuit 11: never stop on laps.
- Precedence within a cycle: circuit==00 > lap stop rule > timeout > normal transitions.
- Turn indicators (feature off): semnal_dreapta = synced senzori[0] & ~fin_raw; semnal_stanga = synced senzori[N_SENZ-1] & ~fin_raw.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous); the FSM restarts in IDLE after deassertion.

Optional Feature:
- Macro: SEMNALIZARE_CLIPIRE_EN.
- Defined:
  - Adds a free-running divider with parameter PERIOADA_CLIPIRE (default 25000000).
  - While a marker condition holds, the corresponding indicator toggles every PERIOADA_CLIPIRE cycles, starting at 1 on the first cycle.
  - In OPRIT, both indicators blink in phase (hazard lights).
  - Indicators are 0 otherwise.
- Undefined: indicators are steady as described under Behaviour; no divider logic.

Test Plan:
- Reset, then circuit=11, senzori=00100 -> after 3 clk: stare=1, directions 10/10, factors 999/999, stop=0.
- senzori=00110 in URMARIRE -> factor_dc_driverA=750, factor_dc_driverB=999. Then 00010 -> factors unchanged, side memory = right. Then 00000 -> stare=2, A=01, B=10, stop=1.
- Stay in CAUTARE with senzori=00000 for TIMEOUT_CAUTARE cycles -> stare=3, pierdut=1, directions 00. circuit=00 -> IDLE, pierdut=0.
- circuit=10: apply 10 finish pulses 10001, each 8 clk wide, separated by 00100 -> count_ture reaches 10, then stare=3. A 3-clk glitch 10001 -> no count.
- circuit=11: hold 10001 for 100 clk -> count_ture increments by exactly 1. Preload 255 laps -> count stays 255.
- Assert rst during CAUTARE -> outputs take reset values within the same cycle. circuit=00 during a finish pulse -> count_ture=0, no increment.

Source files
------------

// File: rtl/control_miscare_param_if.sv
// Sensor/drive bundle between the sensor bar, control_miscare_param and the motor/PWM side.
interface control_miscare_param_if #(
    parameter int N_SENZ = 5,
    parameter int DC_W   = 12,
    parameter int TURE_W = 8
);
    logic [N_SENZ-1:0] senzori;
    logic [1:0]        circuit;
    logic [1:0]        directie_driverA;
    logic [1:0]        directie_driverB;
    logic [DC_W-1:0]   factor_dc_driverA;
    logic [DC_W-1:0]   factor_dc_driverB;
    logic              semnal_dreapta;
    logic              semnal_stanga;
    logic              stop;
    logic [TURE_W-1:0] count_ture;
    logic              pierdut;
    logic [1:0]        stare;

    modport master (
        output senzori, circuit,
        input  directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        input  semnal_dreapta, semnal_stanga, stop, count_ture, pierdut, stare
    );

    modport slave (
        input  senzori, circuit,
        output directie_driverA, directie_driverB, factor_dc_driverA, factor_dc_driverB,
        output semnal_dreapta, semnal_stanga, stop, count_ture, pierdut, stare
    );
endinterface

// File: rtl/control_miscare_param.sv
// Clocked line-follower motion control: follow/search/stop FSM, debounced lap counter, lost-line timeout.
// Define SEMNALIZARE_CLIPIRE_EN for blinking turn indicators and hazard lights while stopped.
module control_miscare_param #(
    parameter int N_SENZ          = 5,
    parameter int DC_W            = 12,
    parameter int DC_MAX          = 'h999,
    parameter int DC_PAS          = 'h249,
    parameter int TURE_W          = 8,
    parameter int DEBOUNCE        = 4,
    parameter int TIMEOUT_CAUTARE = 50000,
    parameter int TURE_CIRCUIT2   = 10
`ifdef SEMNALIZARE_CLIPIRE_EN
    ,
    parameter int PERIOADA_CLIPIRE = 25000000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    control_miscare_param_if.slave bus
);
    localparam int C     = (N_SENZ - 1) / 2;
    localparam int CNT_W = $clog2(TIMEOUT_CAUTARE + 1);
    localparam int DEB_W = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        URMARIRE = 2'd1,
        CAUTARE  = 2'd2,
        OPRIT    = 2'd3
    } stare_t;

    logic [N_SENZ-1:0] r_senz_s1, r_senz_s2;
    logic [1:0]        r_circ_s1, r_circ_s2;
    stare_t            r_stare;
    logic [CNT_W-1:0]  r_cnt_cautare;
    logic [DEB_W-1:0]  r_deb_cnt;
    logic              r_fin_stabil, r_mem_dr, r_mem_st;
    logic [1:0]        r_dir_a, r_dir_b;
    logic [DC_W-1:0]   r_fac_a, r_fac_b;
    logic              r_stop, r_pierdut, r_semn_dr, r_semn_st;
    logic [TURE_W-1:0] r_ture;

    logic              w_dr, w_st, w_linie, w_fin_raw, w_fin_rise, w_clear;
    logic              w_tur_nou, w_stop_tur, w_timeout, w_marker_dr, w_marker_st;
    int                w_d_dr, w_d_st;
    logic [TURE_W-1:0] w_ture_inc;
    stare_t            w_next;

    function automatic logic [DC_W-1:0] f_factor(input int d);
        int red;
        red = d * DC_PAS;
        return (red >= DC_MAX) ? '0 : DC_W'(DC_MAX - red);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_senz_s1 <= '0;
            r_senz_s2 <= '0;
            r_circ_s1 <= '0;
            r_circ_s2 <= '0;
        end else begin
            r_senz_s1 <= bus.senzori;
            r_senz_s2 <= r_senz_s1;
            r_circ_s1 <= bus.circuit;
            r_circ_s2 <= r_circ_s1;
        end
    end

    // Farthest active inner sensor on each side sets how much that side's driver slows down.
    always_comb begin
        w_dr   = 1'b0;
        w_st   = 1'b0;
        w_d_dr = 0;
        w_d_st = 0;
        for (int i = C - 1; i >= 1; i--) begin
            if (r_senz_s2[i]) begin
                w_dr   = 1'b1;
                w_d_dr = C - i;
            end
        end
        for (int i = C + 1; i <= N_SENZ - 2; i++) begin
            if (r_senz_s2[i]) begin
                w_st   = 1'b1;
                w_d_st = i - C;
            end
        end
    end

    assign w_linie     = |r_senz_s2[N_SENZ-2:1];
    assign w_fin_raw   = r_senz_s2[0] & r_senz_s2[N_SENZ-1];
    assign w_marker_dr = r_senz_s2[0] & ~w_fin_raw;
    assign w_marker_st = r_senz_s2[N_SENZ-1] & ~w_fin_raw;
    assign w_clear     = (r_circ_s2 == 2'b00);
    assign w_fin_rise  = w_fin_raw & ~r_fin_stabil & (r_deb_cnt == DEB_W'(DEBOUNCE - 1));
    assign w_ture_inc  = (&r_ture) ? r_ture : r_ture + 1'b1;
    assign w_tur_nou   = w_fin_rise & ((r_stare == URMARIRE) | (r_stare == CAUTARE));
    assign w_stop_tur  = w_tur_nou &
                         (((r_circ_s2 == 2'b01) & (int'(w_ture_inc) >= 1)) |
                          ((r_circ_s2 == 2'b10) & (int'(w_ture_inc) >= TURE_CIRCUIT2)));
    assign w_timeout   = (r_stare == CAUTARE) & ~w_linie &
                         (r_cnt_cautare == CNT_W'(TIMEOUT_CAUTARE - 1));

    always_comb begin
        w_next = r_stare;
        if (w_clear) begin
            w_next = IDLE;
        end else if (w_stop_tur || w_timeout) begin
            w_next = OPRIT;
        end else begin
            case (r_stare)
                IDLE:     w_next = URMARIRE;
                URMARIRE: if (!w_linie) w_next = CAUTARE;
                CAUTARE:  if (w_linie) w_next = URMARIRE;
                default:  w_next = r_stare;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fin_stabil <= 1'b0;
            r_deb_cnt    <= '0;
        end else if (w_fin_raw == r_fin_stabil) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt == DEB_W'(DEBOUNCE - 1)) begin
            r_fin_stabil <= w_fin_raw;
            r_deb_cnt    <= '0;
        end else begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end
    end

`ifdef SEMNALIZARE_CLIPIRE_EN
    localparam int DIV_W = $clog2(PERIOADA_CLIPIRE + 1);

    logic [DIV_W-1:0] r_div;
    logic             r_faza;
    logic             w_avarie, w_activ;

    assign w_avarie = (w_next == OPRIT);
    assign w_activ  = w_marker_dr | w_marker_st | w_avarie;

    // Phase restarts high whenever no indicator is requested, so a new request lights immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_faza <= 1'b1;
        end else if (!w_activ) begin
            r_div  <= '0;
            r_faza <= 1'b1;
        end else if (r_div == DIV_W'(PERIOADA_CLIPIRE - 1)) begin
            r_div  <= '0;
            r_faza <= ~r_faza;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end
`endif

    // Outputs are registered from the next state so they change together with stare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stare       <= IDLE;
            r_cnt_cautare <= '0;
            r_mem_dr      <= 1'b0;
            r_mem_st      <= 1'b0;
            r_ture        <= '0;
            r_pierdut     <= 1'b0;
            r_dir_a       <= 2'b00;
            r_dir_b       <= 2'b00;
            r_fac_a       <= '0;
            r_fac_b       <= '0;
            r_stop        <= 1'b1;
            r_semn_dr     <= 1'b0;
            r_semn_st     <= 1'b0;
        end else begin
            r_stare       <= w_next;
            r_cnt_cautare <= ((r_stare == CAUTARE) && (w_next == CAUTARE)) ? r_cnt_cautare + 1'b1 : '0;
            if (w_clear) begin
                r_ture    <= '0;
                r_pierdut <= 1'b0;
                r_mem_dr  <= 1'b0;
                r_mem_st  <= 1'b0;
            end else begin
                if (w_tur_nou) r_ture <= w_ture_inc;
                if (w_timeout && !w_stop_tur) r_pierdut <= 1'b1;
                if ((w_next == URMARIRE) && (w_dr != w_st)) begin
                    r_mem_dr <= w_dr;
                    r_mem_st <= w_st;
                end
            end
            case (w_next)
                URMARIRE: begin
                    r_dir_a <= 2'b10;
                    r_dir_b <= 2'b10;
                    r_stop  <= 1'b0;
                    r_fac_a <= (w_dr && w_st) ? DC_W'(DC_MAX) : f_factor(w_d_dr);
                    r_fac_b <= (w_dr && w_st) ? DC_W'(DC_MAX) : f_factor(w_d_st);
                end
                CAUTARE: begin
                    r_dir_a <= r_mem_dr ? 2'b01 : 2'b10;
                    r_dir_b <= (r_mem_st && !r_mem_dr) ? 2'b01 : 2'b10;
                    r_stop  <= 1'b1;
                    r_fac_a <= DC_W'(DC_MAX);
                    r_fac_b <= DC_W'(DC_MAX);
                end
                default: begin
                    r_dir_a <= 2'b00;
                    r_dir_b <= 2'b00;
                    r_stop  <= 1'b1;
                    r_fac_a <= '0;
                    r_fac_b <= '0;
                end
            endcase
`ifdef SEMNALIZARE_CLIPIRE_EN
            r_semn_dr <= (w_marker_dr | w_avarie) & r_faza;
            r_semn_st <= (w_marker_st | w_avarie) & r_faza;
`else
            r_semn_dr <= w_marker_dr;
            r_semn_st <= w_marker_st;
`endif
        end
    end

    assign bus.directie_driverA  = r_dir_a;
    assign bus.directie_driverB  = r_dir_b;
    assign bus.factor_dc_driverA = r_fac_a;
    assign bus.factor_dc_driverB = r_fac_b;
    assign bus.semnal_dreapta    = r_semn_dr;
    assign bus.semnal_stanga     = r_semn_st;
    assign bus.stop              = r_stop;
    assign bus.count_ture        = r_ture;
    assign bus.pierdut           = r_pierdut;
    assign bus.stare             = r_stare;
endmodule

// File: tb/tb_control_miscare_param.sv
// Scoreboard bench for control_miscare_param: expectations are queued with a due cycle when stimulus is driven.
module tb_control_miscare_param;
    localparam int T = 300;

    typedef enum int {F_STARE, F_DIRA, F_DIRB, F_FACA, F_FACB, F_STOP, F_TURE, F_PIERDUT, F_SD, F_SS} fieldSel_t;

    typedef struct {
        int        at;
        fieldSel_t fld;
        int        val;
        string     tag;
    } expect_t;

    logic    clk = 1'b0;
    logic    rst = 1'b1;
    int      cyc = 0;
    int      nChecks = 0;
    int      nErrors = 0;
    expect_t sbQueue[$];

    control_miscare_param_if #(.N_SENZ(5), .DC_W(12), .TURE_W(8)) bus ();

    control_miscare_param #(.TIMEOUT_CAUTARE(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    function automatic int readField(input fieldSel_t f);
        case (f)
            F_STARE:   return int'(bus.stare);
            F_DIRA:    return int'(bus.directie_driverA);
            F_DIRB:    return int'(bus.directie_driverB);
            F_FACA:    return int'(bus.factor_dc_driverA);
            F_FACB:    return int'(bus.factor_dc_driverB);
            F_STOP:    return int'(bus.stop);
            F_TURE:    return int'(bus.count_ture);
            F_PIERDUT: return int'(bus.pierdut);
            F_SD:      return int'(bus.semnal_dreapta);
            F_SS:      return int'(bus.semnal_stanga);
            default:   return -1;
        endcase
    endfunction

    // Compare every expectation that falls due on this cycle, away from the active edge.
    always @(negedge clk) begin
        for (int i = sbQueue.size() - 1; i >= 0; i--) begin
            if (sbQueue[i].at == cyc) begin
                checkOutput(sbQueue[i].tag, readField(sbQueue[i].fld), sbQueue[i].val);
                sbQueue.delete(i);
            end
        end
    end

    task automatic pushExpect(input int delay, input string tag, input fieldSel_t f, input int v);
        sbQueue.push_back('{at: cyc + delay, fld: f, val: v, tag: tag});
    endtask

    task automatic expectMotion(input int delay, input string tag, input int st, input int da, input int db,
                                input int fa, input int fb, input int sp);
        pushExpect(delay, {tag, ".stare"}, F_STARE, st);
        pushExpect(delay, {tag, ".dirA"}, F_DIRA, da);
        pushExpect(delay, {tag, ".dirB"}, F_DIRB, db);
        pushExpect(delay, {tag, ".facA"}, F_FACA, fa);
        pushExpect(delay, {tag, ".facB"}, F_FACB, fb);
        pushExpect(delay, {tag, ".stop"}, F_STOP, sp);
    endtask

    task automatic applyStimulus(input logic [4:0] s, input logic [1:0] c);
        bus.senzori = s;
        bus.circuit = c;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        applyStimulus(5'b00000, 2'b00);
        waitCycles(2);
        checkOutput("rst.stare", readField(F_STARE), 0);
        checkOutput("rst.dirA", readField(F_DIRA), 0);
        checkOutput("rst.dirB", readField(F_DIRB), 0);
        checkOutput("rst.facA", readField(F_FACA), 0);
        checkOutput("rst.stop", readField(F_STOP), 1);
        checkOutput("rst.ture", readField(F_TURE), 0);
        checkOutput("rst.pierdut", readField(F_PIERDUT), 0);
        checkOutput("rst.sd", readField(F_SD), 0);
        rst = 1'b0;
        waitCycles(2);

        // Following, latency and steering.
        applyStimulus(5'b00100, 2'b11);
        pushExpect(2, "latency.stare", F_STARE, 0);
        expectMotion(3, "follow", 1, 2, 2, 'h999, 'h999, 0);
        waitCycles(6);
        applyStimulus(5'b00101, 2'b11);
        pushExpect(3, "markR.sd", F_SD, 1);
        pushExpect(3, "markR.ss", F_SS, 0);
        pushExpect(3, "markR.facA", F_FACA, 'h999);
        waitCycles(6);
        applyStimulus(5'b10100, 2'b11);
        pushExpect(3, "markL.sd", F_SD, 0);
        pushExpect(3, "markL.ss", F_SS, 1);
        waitCycles(6);
        applyStimulus(5'b00110, 2'b11);
        expectMotion(3, "devR", 1, 2, 2, 'h750, 'h999, 0);
        waitCycles(6);
        applyStimulus(5'b01110, 2'b11);
        expectMotion(3, "both", 1, 2, 2, 'h999, 'h999, 0);
        waitCycles(6);
        applyStimulus(5'b00010, 2'b11);
        expectMotion(3, "memR", 1, 2, 2, 'h750, 'h999, 0);
        waitCycles(6);

        // Search with right memory, then timeout.
        applyStimulus(5'b00000, 2'b11);
        pushExpect(2, "preSearch.stare", F_STARE, 1);
        expectMotion(3, "searchR", 2, 1, 2, 'h999, 'h999, 1);
        pushExpect(T + 2, "lastSearch.stare", F_STARE, 2);
        pushExpect(T + 2, "lastSearch.pierdut", F_PIERDUT, 0);
        expectMotion(T + 3, "timeout", 3, 0, 0, 0, 0, 1);
        pushExpect(T + 3, "timeout.pierdut", F_PIERDUT, 1);
        waitCycles(T + 6);
        applyStimulus(5'b00000, 2'b00);
        expectMotion(3, "clear", 0, 0, 0, 0, 0, 1);
        pushExpect(3, "clear.pierdut", F_PIERDUT, 0);
        waitCycles(6);

        // Left memory search, then search with memory cleared.
        applyStimulus(5'b01100, 2'b11);
        expectMotion(3, "devL", 1, 2, 2, 'h999, 'h750, 0);
        waitCycles(6);
        applyStimulus(5'b00000, 2'b11);
        expectMotion(3, "searchL", 2, 2, 1, 'h999, 'h999, 1);
        waitCycles(6);
        applyStimulus(5'b00100, 2'b11);
        pushExpect(3, "recover.stare", F_STARE, 1);
        waitCycles(6);
        applyStimulus(5'b00000, 2'b00);
        waitCycles(6);
        applyStimulus(5'b00100, 2'b11);
        waitCycles(6);
        applyStimulus(5'b00000, 2'b11);
        expectMotion(3, "searchN", 2, 2, 2, 'h999, 'h999, 1);
        waitCycles(6);
        applyStimulus(5'b00000, 2'b00);
        waitCycles(6);

        // Circuit 10: stop after TURE_CIRCUIT2 finish lines.
        applyStimulus(5'b00100, 2'b10);
        pushExpect(3, "c2.start", F_STARE, 1);
        waitCycles(6);
        for (int lap = 1; lap <= 10; lap++) begin
            applyStimulus(5'b10001, 2'b10);
            pushExpect(5, $sformatf("lapPre%0d", lap), F_TURE, lap - 1);
            pushExpect(6, $sformatf("lap%0d", lap), F_TURE, lap);
            pushExpect(6, $sformatf("lapState%0d", lap), F_STARE, (lap == 10) ? 3 : 2);
            waitCycles(8);
            applyStimulus(5'b00100, 2'b10);
            pushExpect(3, $sformatf("lapBack%0d", lap), F_STARE, (lap == 10) ? 3 : 1);
            waitCycles(8);
        end
        pushExpect(1, "c2.dirA", F_DIRA, 0);
        waitCycles(2);

        // Debounce boundary: 3-cycle glitch ignored, 4-cycle pulse counted.
        applyStimulus(5'b00100, 2'b00);
        waitCycles(6);
        applyStimulus(5'b00100, 2'b11);
        waitCycles(6);
        applyStimulus(5'b10001, 2'b11);
        waitCycles(3);
        applyStimulus(5'b00100, 2'b11);
        pushExpect(7, "glitch3", F_TURE, 0);
        waitCycles(10);
        applyStimulus(5'b10001, 2'b11);
        pushExpect(6, "pulse4", F_TURE, 1);
        waitCycles(4);
        applyStimulus(5'b00100, 2'b11);
        waitCycles(10);

        // Long finish pulse counts once; endurance count saturates.
        applyStimulus(5'b10001, 2'b11);
        pushExpect(6, "hold", F_TURE, 2);
        pushExpect(99, "holdEnd", F_TURE, 2);
        waitCycles(100);
        applyStimulus(5'b00100, 2'b11);
        waitCycles(10);
        for (int i = 0; i < 260; i++) begin
            applyStimulus(5'b10001, 2'b11);
            if (i == 252) begin
                pushExpect(5, "pre255", F_TURE, 254);
                pushExpect(6, "reach255", F_TURE, 255);
            end
            if (i == 253) pushExpect(6, "noWrap", F_TURE, 255);
            waitCycles(6);
            applyStimulus(5'b00100, 2'b11);
            waitCycles(6);
        end
        pushExpect(1, "sat.ture", F_TURE, 255);
        pushExpect(1, "sat.stare", F_STARE, 1);
        waitCycles(3);

        // Asynchronous reset while searching.
        applyStimulus(5'b00000, 2'b11);
        pushExpect(5, "preRst.stare", F_STARE, 2);
        waitCycles(6);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRst.stare", readField(F_STARE), 0);
        checkOutput("midRst.dirA", readField(F_DIRA), 0);
        checkOutput("midRst.dirB", readField(F_DIRB), 0);
        checkOutput("midRst.facA", readField(F_FACA), 0);
        checkOutput("midRst.stop", readField(F_STOP), 1);
        checkOutput("midRst.ture", readField(F_TURE), 0);
        waitCycles(2);
        rst = 1'b0;
        waitCycles(2);

        // circuit=00 during a finish pulse clears the count and blocks the increment.
        applyStimulus(5'b00100, 2'b11);
        waitCycles(8);
        applyStimulus(5'b10001, 2'b11);
        pushExpect(6, "jLap", F_TURE, 1);
        waitCycles(8);
        applyStimulus(5'b00100, 2'b11);
        waitCycles(10);
        applyStimulus(5'b10001, 2'b00);
        pushExpect(3, "jClr.ture", F_TURE, 0);
        pushExpect(3, "jClr.stare", F_STARE, 0);
        pushExpect(8, "jNoInc", F_TURE, 0);
        waitCycles(8);
        applyStimulus(5'b10001, 2'b11);
        pushExpect(6, "jResume", F_TURE, 0);
        waitCycles(8);

        waitCycles(2);
        checkOutput("sbDrained", sbQueue.size(), 0);
        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
